// File: rtl/rr_packet_arbiter_pkg.sv
// Shared constants and helpers for the round-robin packet arbiter.
package rr_packet_arbiter_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 32;

  // Pointer width for n channels: clog2(n), never below one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    int unsigned w;
    w = 1;
    while ((32'd1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_packet_arbiter_if.sv
// Source/sink bundle between the readout FIFOs, the arbiter and the output FIFO.
interface rr_packet_arbiter_if
  import rr_packet_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) ();

  logic [WIDTH-1:0]            WRITE_REQ;
  logic [WIDTH-1:0]            HOLD_REQ;
  logic [WIDTH*DATA_WIDTH-1:0] DATA_IN;
  logic [WIDTH-1:0]            READ_GRANT;
  logic                        READY_OUT;
  logic                        WRITE_OUT;
  logic [DATA_WIDTH-1:0]       DATA_OUT;

  // Environment side: sources and downstream FIFO.
  modport master (
    output WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
    input  READ_GRANT, WRITE_OUT, DATA_OUT
  );

  // Arbiter side.
  modport slave (
    input  WRITE_REQ, HOLD_REQ, DATA_IN, READY_OUT,
    output READ_GRANT, WRITE_OUT, DATA_OUT
  );

endinterface

// File: rtl/rr_next_select.sv
// Rotating priority encoder: first requester after `last`, wrapping, else `last`.
module rr_next_select
  import rr_packet_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned PW    = ptr_width(WIDTH)
) (
  input  logic [WIDTH-1:0] req,
  input  logic [PW-1:0]    last,
  output logic [PW-1:0]    sel,
  output logic             any_req
);

  localparam int unsigned SW = PW + 1;

  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   rot;
  logic [PW-1:0]      k;
  logic [SW-1:0]      sum;
  logic               found;

  always_comb begin
    dbl     = {req, req};
    rot     = WIDTH'(dbl >> (SW'(last) + SW'(1)));
    any_req = |req;
    k       = '0;
    found   = 1'b0;
    // Lowest set bit of the rotated vector is the nearest requester after last.
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (!found && rot[i]) begin
        k     = PW'(i);
        found = 1'b1;
      end
    end
    sum = SW'(last) + SW'(k) + SW'(1);
    if (sum >= SW'(WIDTH)) sum = sum - SW'(WIDTH);
    sel = any_req ? PW'(sum) : last;
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// Round-robin merge of FWFT sources into one stream, with per-channel packet hold.
module rr_packet_arbiter
  import rr_packet_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH      = 2,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  rr_packet_arbiter_if.slave  bus
);

  localparam int unsigned PW = ptr_width(WIDTH);

  logic [PW-1:0]         last;
  logic [PW-1:0]         rr_sel;
  logic [PW-1:0]         sel;
  logic                  any_req;
  logic                  hold_last;
  logic                  req_sel;
  logic                  write_c;
  logic [DATA_WIDTH-1:0] data_c;
  logic [WIDTH-1:0]      grant_c;

  rr_next_select #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) u_next_select (
    .req     (bus.WRITE_REQ),
    .last    (last),
    .sel     (rr_sel),
    .any_req (any_req)
  );

  // Hold on the last served channel pins the selection even if it has no word.
  always_comb begin
    hold_last = 1'b0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (last == PW'(i)) hold_last = bus.HOLD_REQ[i];
    end
    sel = (hold_last || !any_req) ? last : rr_sel;
  end

  always_comb begin
    req_sel = 1'b0;
    data_c  = bus.DATA_IN[DATA_WIDTH-1:0];
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (sel == PW'(i)) begin
        req_sel = bus.WRITE_REQ[i];
        data_c  = bus.DATA_IN[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    write_c = req_sel && !RST;
    for (int i = 0; i < int'(WIDTH); i++) begin
      grant_c[i] = (sel == PW'(i)) && write_c && bus.READY_OUT;
    end
  end

  assign bus.WRITE_OUT  = write_c;
  assign bus.DATA_OUT   = data_c;
  assign bus.READ_GRANT = grant_c;

  // Pointer advances only on an accepted word.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last <= PW'(WIDTH - 1);
    end else if (write_c && bus.READY_OUT) begin
      last <= sel;
    end
  end

endmodule

// File: tb/tb_rr_packet_arbiter.sv
// Directed bench for rr_packet_arbiter: per-cycle model compare plus literal checkpoints.
module tb_rr_packet_arbiter;

  localparam int W  = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;
  int m_last   = W - 1;

  rr_packet_arbiter_if #(.WIDTH(W), .DATA_WIDTH(DW)) bus ();

  rr_packet_arbiter #(.WIDTH(W), .DATA_WIDTH(DW)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference selection straight from the rotation rules.
  function automatic int m_sel();
    if (bus.HOLD_REQ[m_last]) return m_last;
    for (int k = 1; k <= W; k++) begin
      if (bus.WRITE_REQ[(m_last + k) % W]) return (m_last + k) % W;
    end
    return m_last;
  endfunction

  function automatic logic m_wo();
    return !rst && bus.WRITE_REQ[m_sel()];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m_last = W - 1;
    else if (m_wo() && bus.READY_OUT) m_last = m_sel();
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic [W-1:0] eg;
    int s;
    s  = m_sel();
    eg = '0;
    if (m_wo() && bus.READY_OUT) eg[s] = 1'b1;
    chk("model_write_out", 64'(bus.WRITE_OUT), 64'(m_wo()));
    chk("model_grant", 64'(bus.READ_GRANT), 64'(eg));
    if (m_wo()) chk("model_data", 64'(bus.DATA_OUT), 64'(bus.DATA_IN[s*DW +: DW]));
  end

  // One cycle of stimulus, then literal expectations at the falling edge.
  task automatic cyc(input string name, input logic r, input logic [W-1:0] req,
                     input logic [W-1:0] hold, input logic rdy,
                     input logic [W-1:0] eg, input logic ewo, input logic [DW-1:0] ed);
    @(posedge clk);
    #2;
    rst = r;
    bus.WRITE_REQ = req;
    bus.HOLD_REQ  = hold;
    bus.READY_OUT = rdy;
    @(negedge clk);
    chk({name, "_grant"}, 64'(bus.READ_GRANT), 64'(eg));
    chk({name, "_write_out"}, 64'(bus.WRITE_OUT), 64'(ewo));
    if (ewo) chk({name, "_data"}, 64'(bus.DATA_OUT), 64'(ed));
  endtask

  localparam logic [DW-1:0] D0 = 32'hA5A5_0001;
  localparam logic [DW-1:0] D1 = 32'h5A5A_0002;

  initial begin
    bus.WRITE_REQ = 2'b01;
    bus.HOLD_REQ  = 2'b00;
    bus.READY_OUT = 1'b1;
    bus.DATA_IN   = {D1, D0};

    // Reset then single source.
    cyc("rst_hold", 1'b1, 2'b01, 2'b00, 1'b1, 2'b00, 1'b0, D0);
    for (int i = 0; i < 3; i++) cyc("single", 1'b0, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, D0);

    // Both sources continuous from a fresh reset.
    cyc("rst2", 1'b1, 2'b11, 2'b00, 1'b1, 2'b00, 1'b0, D0);
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) cyc("alt_ch0", 1'b0, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, D0);
      else            cyc("alt_ch1", 1'b0, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, D1);
    end

    // Backpressure freezes selection on channel 0.
    for (int i = 0; i < 3; i++) cyc("bp", 1'b0, 2'b11, 2'b00, 1'b0, 2'b00, 1'b1, D0);
    cyc("bp_rel0", 1'b0, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, D0);
    cyc("bp_rel1", 1'b0, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, D1);

    // Packet lock on channel 0 for four words, then release.
    for (int i = 0; i < 4; i++) cyc("lock", 1'b0, 2'b11, 2'b01, 1'b1, 2'b01, 1'b1, D0);
    cyc("unlock", 1'b0, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, D1);

    // Lock held by an empty channel blocks the other requester.
    cyc("serve0", 1'b0, 2'b01, 2'b00, 1'b1, 2'b01, 1'b1, D0);
    bus.DATA_IN = {32'hCAFE_0010, 32'hBEEF_0020};
    cyc("lock_empty_a", 1'b0, 2'b10, 2'b01, 1'b1, 2'b00, 1'b0, D0);
    cyc("lock_empty_b", 1'b0, 2'b10, 2'b01, 1'b1, 2'b00, 1'b0, D0);
    cyc("drop_hold", 1'b0, 2'b10, 2'b00, 1'b1, 2'b10, 1'b1, 32'hCAFE_0010);
    bus.DATA_IN = {D1, D0};

    // Async reset mid-stream.
    cyc("pre_rst0", 1'b0, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, D0);
    cyc("pre_rst1", 1'b0, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, D1);
    @(posedge clk);
    #2;
    chk("pre_async_write_out", 64'(bus.WRITE_OUT), 64'(1'b1));
    rst = 1'b1;
    #1;
    chk("async_write_out", 64'(bus.WRITE_OUT), 64'(1'b0));
    chk("async_grant", 64'(bus.READ_GRANT), 64'(2'b00));
    @(negedge clk);
    cyc("post_rst", 1'b0, 2'b11, 2'b00, 1'b1, 2'b01, 1'b1, D0);
    cyc("post_rst1", 1'b0, 2'b11, 2'b00, 1'b1, 2'b10, 1'b1, D1);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
